// File: rtl/ap_ctrl_perf_monitor_pkg.sv
// rtl/ap_ctrl_perf_monitor_pkg.sv - shared types and constants for the ap_ctrl_chain performance monitor
package ap_mon_pkg;

    localparam int MON_MAX_CH = 16;

    typedef enum logic [3:0] {
        N_START    = 4'd0,
        N_DONE     = 4'd1,
        LAST_LAT   = 4'd2,
        MIN_LAT    = 4'd3,
        MAX_LAT    = 4'd4,
        LAST_II    = 4'd5,
        MIN_II     = 4'd6,
        MAX_II     = 4'd7,
        START_WAIT = 4'd8,
        DONE_STALL = 4'd9,
        OCC        = 4'd10,
        STATE      = 4'd11
    } ap_mon_field_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BUSY      = 2'd1,
        ST_DONE_WAIT = 2'd2
    } ap_mon_state_e;

endpackage

// File: rtl/ap_ctrl_perf_monitor_if.sv
// rtl/ap_ctrl_perf_monitor_if.sv - per-channel ap_ctrl_chain handshake bundle
interface ap_ctrl_perf_monitor_if #(
    parameter int N_CH = 2
);
    logic [N_CH-1:0] ap_start;
    logic [N_CH-1:0] ap_ready;
    logic [N_CH-1:0] ap_done;
    logic [N_CH-1:0] ap_continue;

    modport master (output ap_start, output ap_ready, output ap_done, output ap_continue);
    modport slave  (input  ap_start, input  ap_ready, input  ap_done, input  ap_continue);
endinterface

// File: rtl/ap_ctrl_perf_monitor_chan.sv
// rtl/ap_ctrl_perf_monitor_chan.sv - one channel: state machine, start-timestamp FIFO, statistics, error flags
module ap_ctrl_chan_monitor
    import ap_mon_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int TS_W  = 32,
    parameter int DEPTH = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            finish,
    input  logic [TS_W-1:0] ts,
    input  logic            ap_start,
    input  logic            ap_ready,
    input  logic            ap_done,
    input  logic            ap_continue,
    input  logic [3:0]      rd_field,
    output logic [TS_W-1:0] rd_data,
    output logic            err_ovf,
    output logic            err_unf,
    output logic            is_idle
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [TS_W-1:0]  ts_t;
    typedef logic [AW:0]      ptr_t;

    function automatic cnt_t sat_inc(input cnt_t v);
        return (&v) ? v : v + cnt_t'(1);
    endfunction

    ts_t  fifo_q [DEPTH];
    ts_t  fifo_d [DEPTH];
    ptr_t wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    cnt_t n_start_q, n_start_d, n_done_q, n_done_d, n_wait_q, n_wait_d, n_stall_q, n_stall_d;
    ts_t  last_lat_q, last_lat_d, min_lat_q, min_lat_d, max_lat_q, max_lat_d;
    ts_t  last_ii_q, last_ii_d, min_ii_q, min_ii_d, max_ii_q, max_ii_d;
    ts_t  last_acc_q, last_acc_d;
    logic first_q, first_d, ovf_q, ovf_d, unf_q, unf_d;
    ap_mon_state_e state_q, state_d;

    logic accept, complete, start_wait, done_stall;
    logic fifo_empty, fifo_full, do_push, do_pop, lat_en;
    ptr_t occ, occ_next;
    ts_t  lat, ii;

    always_comb begin
        accept     = ap_start & ap_ready;
        complete   = ap_done & ap_continue;
        start_wait = ap_start & ~ap_ready;
        done_stall = ap_done & ~ap_continue;
        occ        = wr_ptr_q - rd_ptr_q;
        fifo_empty = (occ == '0);
        fifo_full  = (occ == ptr_t'(DEPTH));
        // An accept/complete pair on an empty FIFO is a zero-latency pass-through.
        lat        = fifo_empty ? '0 : ts - fifo_q[rd_ptr_q[AW-1:0]];
        ii         = ts - last_acc_q;
        do_pop     = !finish && complete && !fifo_empty;
        do_push    = !finish && accept && (complete ? !fifo_empty : !fifo_full);
        lat_en     = !finish && complete && (!fifo_empty || accept);
        occ_next   = occ + ptr_t'(do_push) - ptr_t'(do_pop);

        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        n_start_d  = n_start_q;
        n_done_d   = n_done_q;
        n_wait_d   = n_wait_q;
        n_stall_d  = n_stall_q;
        last_lat_d = last_lat_q;
        min_lat_d  = min_lat_q;
        max_lat_d  = max_lat_q;
        last_ii_d  = last_ii_q;
        min_ii_d   = min_ii_q;
        max_ii_d   = max_ii_q;
        last_acc_d = last_acc_q;
        first_d    = first_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        state_d    = state_q;

        if (do_push) begin
            fifo_d[wr_ptr_q[AW-1:0]] = ts;
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + ptr_t'(1);
        if (lat_en) begin
            last_lat_d = lat;
            if (lat < min_lat_q) min_lat_d = lat;
            if (lat > max_lat_q) max_lat_d = lat;
        end

        if (!finish) begin
            if (start_wait) n_wait_d  = sat_inc(n_wait_q);
            if (done_stall) n_stall_d = sat_inc(n_stall_q);
            if (complete)   n_done_d  = sat_inc(n_done_q);
            if (accept) begin
                n_start_d = sat_inc(n_start_q);
                if (!first_q) begin
                    last_ii_d = ii;
                    if (ii < min_ii_q) min_ii_d = ii;
                    if (ii > max_ii_q) max_ii_d = ii;
                end
                last_acc_d = ts;
                first_d    = 1'b0;
            end
            if (accept && fifo_full && !complete)   ovf_d = 1'b1;
            if (complete && fifo_empty && !accept)  unf_d = 1'b1;

            case (state_q)
                ST_IDLE:      if (accept && !complete) state_d = ST_BUSY;
                ST_BUSY: begin
                    if (complete) begin
                        if (occ_next == '0) state_d = ST_IDLE;
                    end else if (done_stall) begin
                        state_d = ST_DONE_WAIT;
                    end
                end
                ST_DONE_WAIT: if (complete) state_d = (occ_next == '0) ? ST_IDLE : ST_BUSY;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        fifo_q <= fifo_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            n_start_q  <= '0;
            n_done_q   <= '0;
            n_wait_q   <= '0;
            n_stall_q  <= '0;
            last_lat_q <= '0;
            min_lat_q  <= '1;
            max_lat_q  <= '0;
            last_ii_q  <= '0;
            min_ii_q   <= '1;
            max_ii_q   <= '0;
            last_acc_q <= '0;
            first_q    <= 1'b1;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            n_start_q  <= n_start_d;
            n_done_q   <= n_done_d;
            n_wait_q   <= n_wait_d;
            n_stall_q  <= n_stall_d;
            last_lat_q <= last_lat_d;
            min_lat_q  <= min_lat_d;
            max_lat_q  <= max_lat_d;
            last_ii_q  <= last_ii_d;
            min_ii_q   <= min_ii_d;
            max_ii_q   <= max_ii_d;
            last_acc_q <= last_acc_d;
            first_q    <= first_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            state_q    <= state_d;
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_field)
            N_START:    rd_data = ts_t'(n_start_q);
            N_DONE:     rd_data = ts_t'(n_done_q);
            LAST_LAT:   rd_data = last_lat_q;
            MIN_LAT:    rd_data = min_lat_q;
            MAX_LAT:    rd_data = max_lat_q;
            LAST_II:    rd_data = last_ii_q;
            MIN_II:     rd_data = min_ii_q;
            MAX_II:     rd_data = max_ii_q;
            START_WAIT: rd_data = ts_t'(n_wait_q);
            DONE_STALL: rd_data = ts_t'(n_stall_q);
            OCC:        rd_data = ts_t'(occ);
            STATE:      rd_data = ts_t'(state_q);
            default:    rd_data = '0;
        endcase
    end

    assign err_ovf = ovf_q;
    assign err_unf = unf_q;
    assign is_idle = (state_q == ST_IDLE);

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// rtl/ap_ctrl_perf_monitor.sv - top: shared timestamp, per-channel monitors, registered readout and all_idle
module ap_ctrl_perf_monitor
    import ap_mon_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int CNT_W = 32,
    parameter int TS_W  = 32,
    parameter int DEPTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  finish,
    ap_ctrl_perf_monitor_if.slave ctrl,
    input  logic                  rd_en,
    input  logic [3:0]            rd_ch,
    input  logic [3:0]            rd_field,
    output logic                  rd_valid,
    output logic [TS_W-1:0]       rd_data,
    output logic [N_CH-1:0]       err_ovf,
    output logic [N_CH-1:0]       err_unf,
    output logic                  all_idle
);
    localparam int N_RD = (N_CH < MON_MAX_CH) ? N_CH : MON_MAX_CH;

    logic [TS_W-1:0] ts_q, ts_d;
    logic [TS_W-1:0] chan_data [N_CH];
    logic [N_CH-1:0] chan_idle;
    logic            rd_valid_q, rd_valid_d, all_idle_q, all_idle_d;
    logic [TS_W-1:0] rd_data_q, rd_data_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ap_ctrl_chan_monitor #(
            .CNT_W(CNT_W),
            .TS_W (TS_W),
            .DEPTH(DEPTH)
        ) u_chan (
            .clock      (clock),
            .reset      (reset),
            .finish     (finish),
            .ts         (ts_q),
            .ap_start   (ctrl.ap_start[i]),
            .ap_ready   (ctrl.ap_ready[i]),
            .ap_done    (ctrl.ap_done[i]),
            .ap_continue(ctrl.ap_continue[i]),
            .rd_field   (rd_field),
            .rd_data    (chan_data[i]),
            .err_ovf    (err_ovf[i]),
            .err_unf    (err_unf[i]),
            .is_idle    (chan_idle[i])
        );
    end

    always_comb begin
        ts_d       = finish ? ts_q : ts_q + TS_W'(1);
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        // Unpopulated channel selects read as zero.
        if (rd_en) begin
            rd_data_d = '0;
            for (int i = 0; i < N_RD; i++) begin
                if (rd_ch == 4'(i)) rd_data_d = chan_data[i];
            end
        end
        all_idle_d = (&chan_idle) && !(|ctrl.ap_start);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ts_q       <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            all_idle_q <= 1'b1;
        end else begin
            ts_q       <= ts_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            all_idle_q <= all_idle_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign all_idle = all_idle_q;

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// tb/tb_ap_ctrl_perf_monitor.sv - directed and randomized bench with a queue-based reference model
module tb_ap_ctrl_perf_monitor;
    import ap_mon_pkg::*;

    localparam int N_CH  = 2;
    localparam int CNT_W = 32;
    localparam int TS_W  = 32;
    localparam int DEPTH = 8;

    logic            clock = 1'b0;
    logic            reset, finish, rd_en;
    logic [3:0]      rd_ch, rd_field;
    logic            rd_valid;
    logic [TS_W-1:0] rd_data;
    logic [N_CH-1:0] err_ovf, err_unf;
    logic            all_idle;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    ap_ctrl_perf_monitor_if #(.N_CH(N_CH)) ctrl_if ();

    ap_ctrl_perf_monitor #(
        .N_CH (N_CH),
        .CNT_W(CNT_W),
        .TS_W (TS_W),
        .DEPTH(DEPTH)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .finish  (finish),
        .ctrl    (ctrl_if),
        .rd_en   (rd_en),
        .rd_ch   (rd_ch),
        .rd_field(rd_field),
        .rd_valid(rd_valid),
        .rd_data (rd_data),
        .err_ovf (err_ovf),
        .err_unf (err_unf),
        .all_idle(all_idle)
    );

    // Reference model: one timestamp queue per channel plus plain statistics.
    int unsigned m_ts;
    int unsigned mq [N_CH][$];
    longint      m_nstart [N_CH], m_ndone [N_CH], m_wait [N_CH], m_stall [N_CH];
    int unsigned m_last_lat [N_CH], m_min_lat [N_CH], m_max_lat [N_CH];
    int unsigned m_last_ii [N_CH], m_min_ii [N_CH], m_max_ii [N_CH], m_last_acc [N_CH];
    bit          m_first [N_CH], m_ovf [N_CH], m_unf [N_CH], m_held [N_CH];
    logic [31:0] snap [12];

    function automatic void model_reset();
        m_ts = 0;
        for (int ch = 0; ch < N_CH; ch++) begin
            mq[ch].delete();
            m_nstart[ch] = 0; m_ndone[ch] = 0; m_wait[ch] = 0; m_stall[ch] = 0;
            m_last_lat[ch] = 0; m_min_lat[ch] = 32'hFFFF_FFFF; m_max_lat[ch] = 0;
            m_last_ii[ch] = 0;  m_min_ii[ch] = 32'hFFFF_FFFF;  m_max_ii[ch] = 0;
            m_last_acc[ch] = 0; m_first[ch] = 1; m_ovf[ch] = 0; m_unf[ch] = 0; m_held[ch] = 0;
        end
    endfunction

    function automatic void note_lat(int ch, int unsigned v);
        m_last_lat[ch] = v;
        if (v < m_min_lat[ch]) m_min_lat[ch] = v;
        if (v > m_max_lat[ch]) m_max_lat[ch] = v;
    endfunction

    function automatic void note_ii(int ch, int unsigned v);
        m_last_ii[ch] = v;
        if (v < m_min_ii[ch]) m_min_ii[ch] = v;
        if (v > m_max_ii[ch]) m_max_ii[ch] = v;
    endfunction

    function automatic void model_apply();
        bit s, r, d, c, was_empty;
        if (reset) begin
            model_reset();
            return;
        end
        if (finish) return;
        for (int ch = 0; ch < N_CH; ch++) begin
            s = ctrl_if.ap_start[ch]; r = ctrl_if.ap_ready[ch];
            d = ctrl_if.ap_done[ch];  c = ctrl_if.ap_continue[ch];
            was_empty = (mq[ch].size() == 0);
            if (s && !r) m_wait[ch]++;
            if (d && !c) begin
                m_stall[ch]++;
                if (!was_empty) m_held[ch] = 1;
            end
            if (d && c) begin
                m_ndone[ch]++;
                m_held[ch] = 0;
                if (!was_empty)       note_lat(ch, m_ts - mq[ch].pop_front());
                else if (s && r)      note_lat(ch, 0);
                else                  m_unf[ch] = 1;
            end
            if (s && r) begin
                m_nstart[ch]++;
                if (!m_first[ch]) note_ii(ch, m_ts - m_last_acc[ch]);
                m_last_acc[ch] = m_ts;
                m_first[ch] = 0;
                if (!(d && c && was_empty)) begin
                    if (mq[ch].size() < DEPTH) mq[ch].push_back(m_ts);
                    else                       m_ovf[ch] = 1;
                end
            end
        end
        m_ts++;
    endfunction

    function automatic logic [31:0] sat32(longint v);
        return (v > 64'sh0_FFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    function automatic logic [31:0] model_field(int ch, int f);
        if (ch >= N_CH) return 0;
        case (f)
            0:  return sat32(m_nstart[ch]);
            1:  return sat32(m_ndone[ch]);
            2:  return m_last_lat[ch];
            3:  return m_min_lat[ch];
            4:  return m_max_lat[ch];
            5:  return m_last_ii[ch];
            6:  return m_min_ii[ch];
            7:  return m_max_ii[ch];
            8:  return sat32(m_wait[ch]);
            9:  return sat32(m_stall[ch]);
            10: return mq[ch].size();
            11: return (mq[ch].size() == 0) ? 0 : (m_held[ch] ? 2 : 1);
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_vec(int which);
        logic [31:0] v = '0;
        for (int ch = 0; ch < N_CH; ch++) v[ch] = (which == 0) ? m_ovf[ch] : m_unf[ch];
        return v;
    endfunction

    function automatic logic model_idle();
        for (int ch = 0; ch < N_CH; ch++) if (mq[ch].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clock);
        model_apply();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int ch, input bit s, input bit r, input bit d, input bit c);
        ctrl_if.ap_start[ch] = s; ctrl_if.ap_ready[ch] = r;
        ctrl_if.ap_done[ch]  = d; ctrl_if.ap_continue[ch] = c;
    endtask

    task automatic clear_all();
        for (int ch = 0; ch < N_CH; ch++) set_ch(ch, 0, 0, 0, 0);
    endtask

    task automatic rd_chk(input string tag, input int ch, input int f, input logic [31:0] exp);
        rd_en = 1'b1; rd_ch = 4'(ch); rd_field = 4'(f);
        step();
        rd_en = 1'b0;
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk(tag, rd_data, exp);
    endtask

    task automatic rd_model(input int ch, input int f);
        rd_chk($sformatf("ch%0d_f%0d", ch, f), ch, f, model_field(ch, f));
    endtask

    task automatic check_all();
        for (int ch = 0; ch < N_CH; ch++)
            for (int f = 0; f < 12; f++) rd_model(ch, f);
        chk("err_ovf", 32'(err_ovf), model_vec(0));
        chk("err_unf", 32'(err_unf), model_vec(1));
        chk("all_idle", 32'(all_idle), 32'(model_idle()));
    endtask

    task automatic go_ts(input int unsigned t);
        int n = 0;
        while (m_ts != t && n < 5000) begin
            step();
            n++;
        end
        if (n == 5000) begin
            failures++;
            $error("FAIL go_ts timeout observed=%0d expected=%0d", m_ts, t);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; finish = 1'b0; rd_en = 1'b0;
        clear_all();
        step();
        step();
        reset = 1'b0;
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data",  rd_data, 0);
        chk("rst_err_ovf",  32'(err_ovf), 0);
        chk("rst_err_unf",  32'(err_unf), 0);
        chk("rst_all_idle", 32'(all_idle), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; finish = 1'b0; rd_en = 1'b0; rd_ch = '0; rd_field = '0;
        clear_all();

        // Single transaction: accept at ts=10, complete at ts=17.
        do_reset();
        rd_chk("rst_min_lat", 0, 3, 32'hFFFF_FFFF);
        go_ts(10); set_ch(0, 1, 1, 0, 0); step(); clear_all();
        go_ts(17); set_ch(0, 0, 0, 1, 1); step(); clear_all();
        step();
        rd_chk("single_n_start", 0, 0, 1);
        rd_chk("single_n_done",  0, 1, 1);
        rd_chk("single_last_lat", 0, 2, 7);
        rd_chk("single_min_lat", 0, 3, 7);
        rd_chk("single_max_lat", 0, 4, 7);
        chk("single_errs", 32'({err_ovf, err_unf}), 0);
        chk("single_all_idle", 32'(all_idle), 1);

        // Pipelined II on channel 1.
        do_reset();
        go_ts(5);  set_ch(1, 1, 1, 0, 0); step(); clear_all();
        go_ts(8);  set_ch(1, 1, 1, 0, 0); step(); clear_all();
        go_ts(11); set_ch(1, 1, 1, 0, 0); step(); clear_all();
        rd_chk("pipe_occ_peak", 1, 10, 3);
        go_ts(20); set_ch(1, 0, 0, 1, 1); step(); clear_all();
        go_ts(23); set_ch(1, 0, 0, 1, 1); step(); clear_all();
        go_ts(26); set_ch(1, 0, 0, 1, 1); step(); clear_all();
        rd_chk("pipe_min_ii", 1, 6, 3);
        rd_chk("pipe_max_ii", 1, 7, 3);
        rd_chk("pipe_min_lat", 1, 3, 15);
        rd_chk("pipe_max_lat", 1, 4, 15);
        rd_chk("pipe_occ_end", 1, 10, 0);
        check_all();

        // Back-pressure: done held 4 cycles with continue low.
        do_reset();
        go_ts(10); set_ch(0, 1, 1, 0, 0); step(); clear_all();
        go_ts(20); set_ch(0, 0, 0, 1, 0); step(); step();
        rd_chk("bp_state_stall", 0, 11, 2);
        step();
        set_ch(0, 0, 0, 1, 1); step(); clear_all();
        rd_chk("bp_done_stall", 0, 9, 4);
        rd_chk("bp_last_lat", 0, 2, 14);
        rd_chk("bp_state_end", 0, 11, 0);

        // Overflow on ch0, underflow on ch1.
        do_reset();
        set_ch(0, 1, 1, 0, 0);
        repeat (9) step();
        clear_all();
        set_ch(1, 0, 0, 1, 1); step(); clear_all();
        step();
        chk("ovf_err_ovf", 32'(err_ovf), 32'b01);
        chk("ovf_err_unf", 32'(err_unf), 32'b10);
        rd_chk("ovf_n_start", 0, 0, 9);
        rd_chk("ovf_occ", 0, 10, 8);
        rd_chk("unf_n_done", 1, 1, 1);
        rd_chk("unf_min_lat", 1, 3, 32'hFFFF_FFFF);
        check_all();

        // Same-cycle accept and complete on an empty FIFO.
        do_reset();
        go_ts(3); set_ch(0, 1, 1, 1, 1); step(); clear_all();
        step();
        rd_chk("same_last_lat", 0, 2, 0);
        rd_chk("same_state", 0, 11, 0);
        rd_chk("same_n_done", 0, 1, 1);
        chk("same_errs", 32'({err_ovf, err_unf}), 0);

        // Freeze mid-transaction, then reset mid-transaction.
        do_reset();
        go_ts(4); set_ch(0, 1, 1, 0, 0); step(); clear_all();
        go_ts(9);
        finish = 1'b1;
        step();
        for (int f = 0; f < 12; f++) snap[f] = model_field(0, f);
        repeat (20) begin
            for (int ch = 0; ch < N_CH; ch++)
                set_ch(ch, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            step();
        end
        clear_all();
        for (int f = 0; f < 12; f++) rd_chk($sformatf("freeze_f%0d", f), 0, f, snap[f]);
        finish = 1'b0;
        go_ts(12); set_ch(0, 0, 0, 1, 1); step(); clear_all();
        rd_chk("freeze_lat", 0, 2, 8);
        set_ch(1, 1, 1, 0, 0); step(); clear_all(); step();
        reset = 1'b1; step(); step(); reset = 1'b0;
        chk("rst2_all_idle", 32'(all_idle), 1);
        chk("rst2_errs", 32'({err_ovf, err_unf}), 0);
        rd_chk("rst2_min_lat", 1, 3, 32'hFFFF_FFFF);
        check_all();

        // Randomized traffic against the model.
        do_reset();
        for (int round = 0; round < 3; round++) begin
            int pa, pd;
            pa = (round == 1) ? 90 : 50;
            pd = (round == 1) ? 5 : ((round == 2) ? 80 : 40);
            repeat (250) begin
                for (int ch = 0; ch < N_CH; ch++)
                    set_ch(ch, $urandom_range(0, 99) < pa, $urandom_range(0, 99) < 70,
                           $urandom_range(0, 99) < pd, $urandom_range(0, 99) < 60);
                finish = ($urandom_range(0, 15) == 0);
                step();
            end
            clear_all(); finish = 1'b0;
            step(); step();
            check_all();
            rd_chk("bad_ch", 2 + int'($urandom_range(0, 13)), int'($urandom_range(0, 11)), 0);
            rd_chk("bad_field", 0, 12 + int'($urandom_range(0, 3)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ap_ctrl_perf_monitor.md
Name: ap_ctrl_perf_monitor

Overview:
- Synthesizable, parametrised successor to the cosim dataflow status monitor.
- Observes the ap_ctrl_chain handshake (ap_start, ap_ready, ap_done, ap_continue) of N_CH HLS-generated modules or pipelines in parallel.
- Per channel it accumulates transaction counts, per-transaction latency, initiation interval and stall cycles, and flags protocol errors.
- Statistics are read back through a registered readout port. The block is instantiated beside the kernel top in both cosim and on-board debug builds.

Parameters:
N_CH, 2, number of monitored channels (1..16)
CNT_W, 32, width of event and stall counters (saturating)
TS_W, 32, width of the free-running timestamp and of latency/II values
DEPTH, 8, per-channel outstanding-start timestamp FIFO depth (power of two, >=2)

Ports:
clock  in  1  single clock, all logic on the rising edge
reset  in  1  synchronous, active-high; clears all state
finish  in  1  freeze: while high, timestamp and all statistics hold
ap_start  in  N_CH  per-channel ap_start
ap_ready  in  N_CH  per-channel ap_ready
ap_done  in  N_CH  per-channel ap_done
ap_continue  in  N_CH  per-channel ap_continue (tie to 1 for ap_ctrl_hs)
rd_en  in  1  readout request
rd_ch  in  4  channel select
rd_field  in  4  field select (ap_mon_field_e)
rd_valid  out  1  readout data valid, one cycle after rd_en
rd_data  out  TS_W  selected statistic, zero-extended
err_ovf  out  N_CH  sticky: accept with timestamp FIFO full
err_unf  out  N_CH  sticky: complete with no outstanding start
all_idle  out  1  all channel FIFOs empty and no ap_start asserted

Behaviour:
- Reset outputs: rd_valid=0, rd_data=0, err_ovf=0, err_unf=0, all_idle=1.
- Reset internal state: ts=0, counters=0, min fields=all-ones, max fields=0, FIFOs empty, first_accept=1.
- Reset asserted mid-transaction discards outstanding timestamps with no error.
- ts increments by 1 each cycle when finish=0 and wraps modulo 2^TS_W.
- All latency and II arithmetic is unsigned subtraction modulo 2^TS_W, so one wrap is tolerated.
- Per channel events are sampled each cycle; nothing is recorded while finish=1:
  - accept = ap_start & ap_ready
  - complete = ap_done & ap_continue
  - start_wait = ap_start & ~ap_ready
  - done_stall = ap_done & ~ap_continue
- accept: n_start++ and push ts onto the FIFO.
  - If first_accept=0: ii = ts - last_accept_ts, then update last_ii, min_ii, max_ii.
  - Then last_accept_ts=ts and first_accept=0.
- complete: n_done++ and pop the head.
  - lat = ts - head, then update last_lat, min_lat, max_lat.
- Same-cycle accept and complete:
  - FIFO empty: lat=0, nothing pushed, no error (combinational-latency module).
  - FIFO full: pop and push both happen, no overflow.
  - Otherwise: pop the old head, push the new ts.
- accept with FIFO full and no complete: the push is dropped, err_ovf[ch] is set, and n_start still increments.
- complete with FIFO empty and no accept: err_unf[ch] is set, n_done increments, lat fields are unchanged.
- start_wait and done_stall each increment their own counter once per cycle.
- All counters saturate at 2^CNT_W-1.
- Readout has 1-cycle latency: rd_valid <= rd_en and rd_data <= mux(rd_ch, rd_field) as sampled on the rd_en cycle.
  - rd_ch >= N_CH or an undefined field returns 0.
  - Readout works while finish=1.
- Channel state machine (internal, readable as field STATE):
  - IDLE, go to BUSY on accept with no same-cycle complete.
  - BUSY (FIFO non-empty, ap_done low), go to DONE_WAIT on done_stall, back to IDLE when the FIFO empties on complete.
  - DONE_WAIT, go to BUSY or IDLE on complete, by FIFO occupancy after the pop.
  - Encoding: IDLE=0, BUSY=1, DONE_WAIT=2.
- all_idle is registered: 1 when every channel is in IDLE and ap_start=0.

Decomposition:
- Package ap_mon_pkg holds:
  - typedef enum ap_mon_field_e: N_START=0, N_DONE=1, LAST_LAT=2, MIN_LAT=3, MAX_LAT=4, LAST_II=5, MIN_II=6, MAX_II=7, START_WAIT=8, DONE_STALL=9, OCC=10, STATE=11.
  - typedef enum ap_mon_state_e.
  - Constant MON_MAX_CH=16.
- Sub-module ap_ctrl_chan_monitor holds one channel's FSM, timestamp FIFO, counters and error flags, generated N_CH times.
- The top level holds the shared timestamp, the readout mux and all_idle.

Test Plan:
- Single transaction: ch0 ap_start=1 at ts=10 with ap_ready=1 for 1 cycle, ap_done=1 at ts=17 with ap_continue=1 -> N_START=1, N_DONE=1, LAST_LAT=MIN_LAT=MAX_LAT=7, err_ovf=err_unf=0.
- Pipelined II: ch1 accepts at ts=5, 8, 11, completes at ts=20, 23, 26 -> MIN_II=MAX_II=3, LAT=15 each, OCC peaks at 3.
- Back-pressure: ch0 ap_done held with ap_continue=0 for 4 cycles -> DONE_STALL=4, STATE=2 during the stall, latency includes the stall.
- Overflow: DEPTH=8 with 9 accepts and no completes -> err_ovf[ch]=1 and N_START=9. A complete with an empty FIFO on another channel -> err_unf set, n_done=1.
- Same-cycle accept and complete on an empty FIFO -> LAST_LAT=0, no error, STATE stays IDLE.
- Freeze and reset: set finish=1 mid-transaction -> readout values hold for 20 cycles. Assert reset -> all fields return to reset values, MIN_LAT reads 0xFFFFFFFF, all_idle=1.
